// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared types and constants for the 8x8 LED matrix scan sequencer.
package matrix_scan_ctrl_pkg;

  localparam int NUM_COLS = 8;
  localparam int COL_W    = 3;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Never below 1 bit, so a 1-cycle interval still gets a usable counter.
  function automatic int timer_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/matrix_scan_ctrl_frame_bank_2x64.sv
// Double-buffered 8x8 frame store: host writes the back bank, the scanner reads the front.
module frame_bank_2x64
  import matrix_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             swap,
  input  logic [COL_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] bank0 [NUM_COLS];
  logic [7:0] bank1 [NUM_COLS];
  logic       bank_sel;

  // bank_sel selects the front bank. A write coinciding with a swap lands in
  // the old back bank, which is exactly the bank that becomes the new front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      bank_sel <= 1'b0;
    end else begin
      if (wr_en) begin
        if (bank_sel) bank0[wr_addr] <= wr_data;
        else          bank1[wr_addr] <= wr_data;
      end
      if (swap) bank_sel <= ~bank_sel;
    end
  end

  assign rd_data = bank_sel ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column scan sequencer for the 8x8 LED matrix with tear-free frame bank swapping.
//   state | meaning
//   BLANK | all columns off, timer counts the blanking interval
//   SHOW  | column col_idx lit with front-bank row data, timer counts the dwell
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES = 256,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [COL_W-1:0]    wr_addr,
  input  logic [7:0]          wr_data,
  input  logic                swap_req,
  output logic [NUM_COLS-1:0] col_drive,
  output logic [7:0]          row_drive,
  output logic [COL_W-1:0]    col_idx,
  output logic                frame_tick,
  output logic                swap_pending,
  output logic                swap_done
);

  localparam int               TW         = timer_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [TW-1:0]    DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0]    BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);

  scan_state_e         state;
  logic [TW-1:0]       timer;
  logic [7:0]          front_row;
  logic [NUM_COLS-1:0] col_dec;
  logic                dwell_done;
  logic                frame_end;
  logic                do_swap;

  assign dwell_done = enable && (state == SHOW) && (timer == DWELL_LAST);
  assign frame_end  = dwell_done && (col_idx == LAST_COL);
  assign do_swap    = frame_end && (swap_pending || swap_req);

  always_comb begin
    col_dec          = '0;
    col_dec[col_idx] = 1'b1;
  end

  frame_bank_2x64 u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .swap    (do_swap),
    .rd_addr (col_idx),
    .rd_data (front_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BLANK;
      timer        <= '0;
      col_idx      <= '0;
      col_drive    <= '0;
      row_drive    <= '0;
      frame_tick   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      swap_done  <= 1'b0;
      if (swap_req) swap_pending <= 1'b1;

      if (!enable) begin
        state     <= BLANK;
        timer     <= '0;
        col_idx   <= '0;
        col_drive <= '0;
        row_drive <= '0;
      end else begin
        case (state)
          BLANK: begin
            if (timer == BLANK_LAST) begin
              state     <= SHOW;
              timer     <= '0;
              col_drive <= col_dec;
              row_drive <= front_row;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          SHOW: begin
            if (timer == DWELL_LAST) begin
              state     <= BLANK;
              timer     <= '0;
              col_idx   <= col_idx + 1'b1;
              col_drive <= '0;
              row_drive <= '0;
              if (frame_end) frame_tick <= 1'b1;
              if (do_swap) begin
                swap_done    <= 1'b1;
                swap_pending <= 1'b0;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= BLANK;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with DWELL=4, BLANK=2 (6 cycles/column, 48/frame).
module tb_matrix_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       swap_req;
  logic [7:0] col_drive;
  logic [7:0] row_drive;
  logic [2:0] col_idx;
  logic       frame_tick;
  logic       swap_pending;
  logic       swap_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic [7:0] front_m [8];
  logic [7:0] back_m  [8];

  always #5 clk = ~clk;

  matrix_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .col_drive    (col_drive),
    .row_drive    (row_drive),
    .col_idx      (col_idx),
    .frame_tick   (frame_tick),
    .swap_pending (swap_pending),
    .swap_done    (swap_done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // cyc = number of rising edges since scanning (re)started; samples at negedge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [7:0] exp_col(input int c);
    logic [7:0] one;
    one = 8'h01;
    if ((c % 6) >= 2) return one << ((c / 6) % 8);
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_row(input int c);
    if ((c % 6) >= 2) return front_m[(c / 6) % 8];
    return 8'h00;
  endfunction

  function automatic void model_swap();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t = front_m[i]; front_m[i] = back_m[i]; back_m[i] = t;
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    wr_addr = 3'd0; wr_data = 8'h00;
    for (int i = 0; i < 8; i++) begin front_m[i] = 8'h00; back_m[i] = 8'h00; end
    repeat (3) @(negedge clk);
    n_checks++; if (col_drive !== 8'h00) begin n_fail++; $display("FAIL reset_col_drive got %h exp 00", col_drive); end
    n_checks++; if (row_drive !== 8'h00) begin n_fail++; $display("FAIL reset_row_drive got %h exp 00", row_drive); end
    n_checks++; if (col_idx !== 3'd0) begin n_fail++; $display("FAIL reset_col_idx got %0d exp 0", col_idx); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
    n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_swap_pending got %b exp 0", swap_pending); end
    n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL reset_swap_done got %b exp 0", swap_done); end
    enable = 1'b1;
    rst_n  = 1'b1;
    cyc    = 0;
  endtask

  task automatic test_cadence();
    int ticks;
    ticks = 0;
    for (int i = 0; i <= 96; i++) begin
      if (i > 0) step();
      if (frame_tick === 1'b1) ticks++;
      n_checks++; if (col_drive !== exp_col(cyc)) begin n_fail++; $display("FAIL cadence_col_drive cyc %0d got %h exp %h", cyc, col_drive, exp_col(cyc)); end
      n_checks++; if (col_idx !== 3'((cyc / 6) % 8)) begin n_fail++; $display("FAIL cadence_col_idx cyc %0d got %0d exp %0d", cyc, col_idx, (cyc / 6) % 8); end
      n_checks++; if (row_drive !== 8'h00) begin n_fail++; $display("FAIL cadence_row_drive cyc %0d got %h exp 00", cyc, row_drive); end
      n_checks++; if (frame_tick !== (cyc > 0 && cyc % 48 == 0)) begin n_fail++; $display("FAIL cadence_frame_tick cyc %0d got %b", cyc, frame_tick); end
    end
    n_checks++; if (ticks != 2) begin n_fail++; $display("FAIL cadence_tick_count got %0d exp 2", ticks); end
  endtask

  task automatic test_write_swap();
    while (cyc < 110) step();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; back_m[3] = 8'hA5;
    step();
    wr_en = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    while (cyc < 144) begin
      n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL ws_pending cyc %0d got %b exp 1", cyc, swap_pending); end
      n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL ws_early_done cyc %0d got %b exp 0", cyc, swap_done); end
      step();
    end
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL ws_frame_tick got %b exp 1", frame_tick); end
    n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL ws_swap_done got %b exp 1", swap_done); end
    n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL ws_pending_clear got %b exp 0", swap_pending); end
    model_swap();
    while (cyc < 164) step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (col_drive !== 8'h08) begin n_fail++; $display("FAIL ws_col3_drive cyc %0d got %h exp 08", cyc, col_drive); end
      n_checks++; if (row_drive !== 8'hA5) begin n_fail++; $display("FAIL ws_col3_row cyc %0d got %h exp a5", cyc, row_drive); end
      step();
    end
  endtask

  task automatic test_swap_at_frame_end();
    while (cyc < 191) step();
    n_checks++; if (col_drive !== 8'h80) begin n_fail++; $display("FAIL fe_last_col got %h exp 80", col_drive); end
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h3C; back_m[0] = 8'h3C;
    step();
    swap_req = 1'b0; wr_en = 1'b0;
    n_checks++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL fe_frame_tick got %b exp 1", frame_tick); end
    n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL fe_swap_done got %b exp 1", swap_done); end
    n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL fe_pending got %b exp 0", swap_pending); end
    model_swap();
    while (cyc < 194) step();
    n_checks++; if (col_drive !== 8'h01) begin n_fail++; $display("FAIL fe_col0_drive got %h exp 01", col_drive); end
    n_checks++; if (row_drive !== 8'h3C) begin n_fail++; $display("FAIL fe_col0_row got %h exp 3c", row_drive); end
    while (cyc < 212) step();
    n_checks++; if (col_drive !== 8'h08) begin n_fail++; $display("FAIL fe_col3_drive got %h exp 08", col_drive); end
    n_checks++; if (row_drive !== 8'h00) begin n_fail++; $display("FAIL fe_col3_row got %h exp 00", row_drive); end
  endtask

  task automatic test_front_protect();
    int n_col0;
    n_col0 = 0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; back_m[0] = 8'hFF;
    step();
    wr_en = 1'b0;
    while (cyc < 384) begin
      step();
      if (exp_col(cyc) == 8'h01 && row_drive === 8'h3C) n_col0++;
      n_checks++; if (row_drive !== exp_row(cyc)) begin n_fail++; $display("FAIL fp_row cyc %0d got %h exp %h", cyc, row_drive, exp_row(cyc)); end
      n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL fp_swap_done cyc %0d got %b exp 0", cyc, swap_done); end
    end
    n_checks++; if (n_col0 != 12) begin n_fail++; $display("FAIL fp_col0_count got %0d exp 12", n_col0); end
  endtask

  task automatic test_enable_drop();
    while (cyc < 417) step();
    n_checks++; if (col_drive !== 8'h20) begin n_fail++; $display("FAIL en_col5 got %h exp 20", col_drive); end
    enable = 1'b0;
    step();
    n_checks++; if (col_drive !== 8'h00) begin n_fail++; $display("FAIL en_col_drive got %h exp 00", col_drive); end
    n_checks++; if (row_drive !== 8'h00) begin n_fail++; $display("FAIL en_row_drive got %h exp 00", row_drive); end
    n_checks++; if (col_idx !== 3'd0) begin n_fail++; $display("FAIL en_col_idx got %0d exp 0", col_idx); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL en_frame_tick got %b exp 0", frame_tick); end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL en_pending cyc %0d got %b exp 1", i, swap_pending); end
      n_checks++; if (frame_tick !== 1'b0 || col_drive !== 8'h00) begin n_fail++; $display("FAIL en_idle cyc %0d tick %b col %h exp 0 00", i, frame_tick, col_drive); end
      step();
    end
    enable = 1'b1;
    cyc = 0;
    n_checks++; if (col_drive !== 8'h00) begin n_fail++; $display("FAIL en_restart0 got %h exp 00", col_drive); end
    step();
    n_checks++; if (col_drive !== 8'h00) begin n_fail++; $display("FAIL en_restart1 got %h exp 00", col_drive); end
    step();
    n_checks++; if (col_drive !== 8'h01) begin n_fail++; $display("FAIL en_restart2 got %h exp 01", col_drive); end
    n_checks++; if (row_drive !== 8'h3C) begin n_fail++; $display("FAIL en_restart_row got %h exp 3c", row_drive); end
  endtask

  task automatic test_async_reset();
    while (cyc < 27) step();
    n_checks++; if (col_drive !== 8'h10) begin n_fail++; $display("FAIL ar_pre_col got %h exp 10", col_drive); end
    n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL ar_pre_pending got %b exp 1", swap_pending); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (col_drive !== 8'h00) begin n_fail++; $display("FAIL ar_col_drive got %h exp 00", col_drive); end
    n_checks++; if (row_drive !== 8'h00) begin n_fail++; $display("FAIL ar_row_drive got %h exp 00", row_drive); end
    n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL ar_pending got %b exp 0", swap_pending); end
    n_checks++; if (col_idx !== 3'd0) begin n_fail++; $display("FAIL ar_col_idx got %0d exp 0", col_idx); end
    for (int i = 0; i < 8; i++) begin front_m[i] = 8'h00; back_m[i] = 8'h00; end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 96) begin
      step();
      if (cyc == 10) swap_req = 1'b1;
      else swap_req = 1'b0;
      n_checks++; if (col_drive !== exp_col(cyc)) begin n_fail++; $display("FAIL ar_col cyc %0d got %h exp %h", cyc, col_drive, exp_col(cyc)); end
      n_checks++; if (row_drive !== 8'h00) begin n_fail++; $display("FAIL ar_bank_zero cyc %0d got %h exp 00", cyc, row_drive); end
      if (cyc == 48) begin
        n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL ar_swap_done got %b exp 1", swap_done); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_write_swap();
    test_swap_at_frame_end();
    test_front_protect();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
